// File: rtl/jtroadf_objrom_arb.sv
// Object/scroll ROM slot arbiter: two requesters share one SDRAM port.
// Each requester keeps a one-entry tagged result register and sees a plain cs/addr/ok/data interface.

module jtroadf_objrom_slot #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          clr,
  input  logic          load,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ok,
  output logic [DW-1:0] data,
  output logic          pend
);
  logic [AW-1:0] tag_q, tag_d;
  logic          tv_q, tv_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    tag_d  = tag_q;
    tv_d   = tv_q;
    data_d = data_q;
    if (clr) tv_d = 1'b0;
    if (load) begin
      tag_d  = ld_addr;
      tv_d   = 1'b1;
      data_d = ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q  <= '0;
      tv_q   <= 1'b0;
      data_q <= '0;
    end else begin
      tag_q  <= tag_d;
      tv_q   <= tv_d;
      data_q <= data_d;
    end
  end

  assign ok   = cs & tv_q & (addr == tag_q);
  assign pend = cs & ~ok;
  assign data = data_q;
endmodule

module jtroadf_objrom_arb #(
  parameter int   AW       = 14,
  parameter int   DW       = 32,
  parameter logic OBJ_PRIO = 1'b1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic          obj_ok,
  output logic [DW-1:0] obj_data,
  input  logic          scr_cs,
  input  logic [AW-1:0] scr_addr,
  output logic          scr_ok,
  output logic [DW-1:0] scr_data,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ok,
  input  logic [DW-1:0] rom_data,
  output logic          sel
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // Requester index 1 = obj, 0 = scr, matching the sel encoding.
  logic [1:0]           cs_a, ok_a, pend_a, clr_a, load_a;
  logic [1:0][AW-1:0]   addr_a;
  logic [1:0][DW-1:0]   data_a;

  state_t        state_q, state_d;
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          win;

  assign cs_a   = {obj_cs, scr_cs};
  assign addr_a = {obj_addr, scr_addr};

  for (genvar g = 0; g < 2; g++) begin : g_slot
    jtroadf_objrom_slot #(.AW(AW), .DW(DW)) u_slot (
      .rst    (rst),
      .clk    (clk),
      .cs     (cs_a[g]),
      .addr   (addr_a[g]),
      .clr    (clr_a[g]),
      .load   (load_a[g]),
      .ld_addr(rom_addr_q),
      .ld_data(rom_data),
      .ok     (ok_a[g]),
      .data   (data_a[g]),
      .pend   (pend_a[g])
    );
  end

  // Round-robin only matters on a tie; a lone pending requester always wins.
  assign win = (pend_a[1] & pend_a[0]) ? ~last_q : pend_a[1];

  always_comb begin
    state_d    = state_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    sel_d      = sel_q;
    last_d     = last_q;
    clr_a      = '0;
    load_a     = '0;
    case (state_q)
      S_IDLE: if (|pend_a) begin
        sel_d       = win;
        rom_addr_d  = addr_a[win];
        rom_cs_d    = 1'b1;
        clr_a[win]  = 1'b1;
        state_d     = S_ISSUE;
      end
      // rom_ok may still be high from the previous access here
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: if (rom_ok) begin
        load_a[sel_q] = 1'b1;
        rom_cs_d      = 1'b0;
        last_d        = sel_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      sel_q      <= OBJ_PRIO;
      last_q     <= ~OBJ_PRIO;
    end else begin
      state_q    <= state_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
    end
  end

  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign sel      = sel_q;
  assign obj_ok   = ok_a[1];
  assign scr_ok   = ok_a[0];
  assign obj_data = data_a[1];
  assign scr_data = data_a[0];
endmodule
